// File: rtl/led_seq_master_if.sv
// AXI4-Lite write channels between the LED sequencer (master) and the LED
// controller or interconnect (slave). The read channels are absent: the sequencer never reads.
interface led_seq_master_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/led_seq_master.sv
// Autonomous LED animation sequencer: once per TICK_DIV cycles it rewrites the
// 18 duty registers of the LED PWM controller over AXI4-Lite, one write at a time.
module led_seq_master #(
   parameter int unsigned TICK_DIV = 50000,
   parameter logic [31:0] BASE     = 32'h0
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     enable,
   input  logic [1:0]               mode,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     err,
   led_seq_master_if.master         m_axi
);

   localparam int unsigned TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_RESP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [TW-1:0]   r_tick;
   logic            r_pending;
   logic [7:0]      r_phase;
   logic [1:0]      r_mode_q;
   logic [4:0]      r_idx;
   logic            r_awvalid;
   logic            r_wvalid;
   logic [31:0]     r_awaddr;
   logic [31:0]     r_wdata;
   logic [3:0]      r_wstrb;
   logic            r_frame_done;
   logic            r_err;

   logic            w_wrap;
   logic            w_start;
   logic            w_send_done;
   logic            w_b_acc;
   logic            w_last;
   logic            w_load;
   logic [4:0]      w_load_idx;
   logic [1:0]      w_load_mode;

   // Duty value for one register; the triangle wave t folds phase into 0..254..0.
   function automatic logic [15:0] f_duty(input logic [1:0] md, input logic [4:0] idx,
                                          input logic [7:0] ph);
      logic [7:0] t;
      t = ph[7] ? {~ph[6:0], 1'b0} : {ph[6:0], 1'b0};
      f_duty = 16'h0000;
      if (!idx[4]) begin
         case (md)
            2'd0:    f_duty = (idx[3:0] == ph[3:0]) ? 16'h0000 : 16'h00FF;
            2'd1:    f_duty = {8'h00, t};
            2'd2:    f_duty = 16'h00FF;
            default: f_duty = 16'h0000;
         endcase
      end else begin
         case (md)
            2'd2:    f_duty = 16'hFFFF;
            2'd3:    f_duty = 16'h0000;
            default: f_duty = (idx[0] == 1'b0) ? {~t, t} : {t, ~t};
         endcase
      end
   endfunction

   assign w_wrap      = (r_tick == TW'(TICK_DIV - 1));
   assign w_start     = (r_state == S_IDLE) && r_pending;
   // A channel is finished once its valid has dropped or its ready is seen now.
   assign w_send_done = (!r_awvalid || m_axi.awready) && (!r_wvalid || m_axi.wready);
   assign w_b_acc     = (r_state == S_RESP) && m_axi.bvalid;
   assign w_last      = (r_idx == 5'd17);
   assign w_load      = w_start || (w_b_acc && !w_last);
   assign w_load_idx  = w_start ? 5'd0 : r_idx + 5'd1;
   assign w_load_mode = w_start ? mode : r_mode_q;

   // NOTE: reset is sampled on the clock edge only (synchronous, active-low), so it
   // sits inside the clocked branch rather than in the sensitivity list.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: every register in a clocked process uses <= so all of them update
         // together from the pre-edge values.
         r_state <= w_next;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves w_next unassigned,
      // which would otherwise infer a latch.
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_pending) w_next = S_SEND;
         S_SEND:  if (w_send_done) w_next = S_RESP;
         S_RESP:  if (m_axi.bvalid) w_next = w_last ? S_IDLE : S_SEND;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_tick       <= '0;
         r_pending    <= 1'b0;
         r_phase      <= 8'd0;
         r_mode_q     <= 2'd0;
         r_idx        <= 5'd0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_awaddr     <= BASE;
         r_wdata      <= 32'd0;
         r_wstrb      <= 4'd0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_tick <= w_wrap ? '0 : r_tick + TW'(1);

         // One-deep request: a wrap that finds pending already set is dropped.
         if (w_start)              r_pending <= 1'b0;
         else if (w_wrap && enable) r_pending <= 1'b1;

         if (w_start) r_mode_q <= mode;
         if (w_load)  r_idx    <= w_load_idx;

         if (w_load)              r_awvalid <= 1'b1;
         else if (m_axi.awready)  r_awvalid <= 1'b0;
         if (w_load)              r_wvalid  <= 1'b1;
         else if (m_axi.wready)   r_wvalid  <= 1'b0;

         if (w_load) begin
            r_awaddr <= BASE + {25'd0, w_load_idx, 2'b00};
            r_wdata  <= {16'h0000, f_duty(w_load_mode, w_load_idx, r_phase)};
            r_wstrb  <= w_load_idx[4] ? 4'b0011 : 4'b0001;
         end

         r_frame_done <= w_b_acc && w_last;
         if (w_b_acc && w_last)                r_phase <= r_phase + 8'd1;
         if (w_b_acc && (m_axi.bresp != 2'b00)) r_err  <= 1'b1;
      end
   end

   assign busy          = (r_state != S_IDLE);
   assign frame_done    = r_frame_done;
   assign err           = r_err;
   assign m_axi.awvalid = r_awvalid;
   assign m_axi.awaddr  = r_awaddr;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.wvalid  = r_wvalid;
   assign m_axi.wdata   = r_wdata;
   assign m_axi.wstrb   = r_wstrb;
   assign m_axi.bready  = (r_state == S_RESP);

endmodule

// File: tb/tb_led_seq_master.sv
// Directed bench for led_seq_master: a configurable AXI-Lite slave logs every
// write; each task drives one scenario and compares against hand-computed values.
module tb_led_seq_master;
   localparam int unsigned TICK_DIV = 64;
   localparam logic [31:0] BASE     = 32'h0;

   logic       aclk    = 1'b0;
   logic       aresetn = 1'b0;
   logic       enable  = 1'b0;
   logic [1:0] mode    = 2'd0;
   logic       busy, frame_done, err;

   led_seq_master_if m_axi();

   led_seq_master #(.TICK_DIV(TICK_DIV), .BASE(BASE)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .enable     (enable),
      .mode       (mode),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err),
      .m_axi      (m_axi)
   );

   always #5 aclk = ~aclk;

   int n_pass  = 0;
   int n_total = 0;

   // Slave model configuration (written only by the stimulus process)
   int aw_delay = 0;
   int w_delay  = 0;
   int err_idx  = -1;

   // Slave model state
   int          aw_cnt = 0, w_cnt = 0;
   logic        aw_got = 1'b0, w_got = 1'b0;
   logic [31:0] got_addr = '0, got_data = '0;
   logic [3:0]  got_strb = '0;
   logic        bvalid_r = 1'b0;
   logic [1:0]  bresp_r = 2'b00;
   logic [31:0] log_addr [0:255];
   logic [31:0] log_data [0:255];
   logic [3:0]  log_strb [0:255];
   int          wr_cnt = 0, b_cnt = 0, stab_err = 0;
   logic        prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
   logic [31:0] prev_awaddr = '0, prev_wdata = '0;
   logic [3:0]  prev_wstrb = '0;

   assign m_axi.awready = m_axi.awvalid && (aw_cnt >= aw_delay);
   assign m_axi.wready  = m_axi.wvalid && (w_cnt >= w_delay);
   assign m_axi.bvalid  = bvalid_r;
   assign m_axi.bresp   = bresp_r;

   always @(posedge aclk) begin
      logic        a_now, d_now;
      logic [31:0] addr_now, data_now;
      logic [3:0]  strb_now;
      if (!aresetn) begin
         aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         bvalid_r <= 1'b0; bresp_r <= 2'b00;
         prev_aw_stall <= 1'b0; prev_w_stall <= 1'b0;
      end else begin
         aw_cnt <= (!m_axi.awvalid || m_axi.awready) ? 0 : aw_cnt + 1;
         w_cnt  <= (!m_axi.wvalid || m_axi.wready) ? 0 : w_cnt + 1;
         a_now    = aw_got || (m_axi.awvalid && m_axi.awready);
         d_now    = w_got || (m_axi.wvalid && m_axi.wready);
         addr_now = aw_got ? got_addr : m_axi.awaddr;
         data_now = w_got ? got_data : m_axi.wdata;
         strb_now = w_got ? got_strb : m_axi.wstrb;
         if (m_axi.awvalid && m_axi.awready) begin got_addr <= m_axi.awaddr; aw_got <= 1'b1; end
         if (m_axi.wvalid && m_axi.wready) begin
            got_data <= m_axi.wdata; got_strb <= m_axi.wstrb; w_got <= 1'b1;
         end
         if (bvalid_r && m_axi.bready) begin bvalid_r <= 1'b0; b_cnt <= b_cnt + 1; end
         if (a_now && d_now) begin
            log_addr[wr_cnt % 256] <= addr_now;
            log_data[wr_cnt % 256] <= data_now;
            log_strb[wr_cnt % 256] <= strb_now;
            wr_cnt   <= wr_cnt + 1;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_r <= 1'b1;
            bresp_r  <= (err_idx >= 0 && addr_now == BASE + 32'(4 * err_idx)) ? 2'b10 : 2'b00;
         end
         // A stalled valid must stay high with its payload unchanged.
         if (prev_aw_stall && (!m_axi.awvalid || m_axi.awaddr != prev_awaddr)) stab_err <= stab_err + 1;
         if (prev_w_stall && (!m_axi.wvalid || m_axi.wdata != prev_wdata || m_axi.wstrb != prev_wstrb))
            stab_err <= stab_err + 1;
         prev_aw_stall <= m_axi.awvalid && !m_axi.awready;
         prev_w_stall  <= m_axi.wvalid && !m_axi.wready;
         prev_awaddr   <= m_axi.awaddr;
         prev_wdata    <= m_axi.wdata;
         prev_wstrb    <= m_axi.wstrb;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers (no comparisons inside) ----------------
   task automatic do_reset();
      @(negedge aclk); aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic wait_awvalid(input int budget, output logic ok, output int n);
      ok = 1'b0; n = 0;
      while (n < budget) begin
         @(negedge aclk); n++;
         if (m_axi.awvalid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_addr(input logic [31:0] a, input int budget, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge aclk);
         if (m_axi.awvalid && m_axi.awaddr == a) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_frame_done(input int budget, output logic ok, output int n, output int busy_n);
      ok = 1'b0; n = 0; busy_n = 0;
      while (n < budget) begin
         @(negedge aclk); n++;
         if (frame_done) begin ok = 1'b1; break; end
         if (busy) busy_n++;
      end
   endtask

   function automatic logic [31:0] exp_breathe0(input int i);
      if (i < 16)  return 32'h0000_0000;
      if (i == 16) return 32'h0000_FF00;
      return 32'h0000_00FF;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      n_total++; if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready} !== 3'b000)
         $display("FAIL reset_valids: got %b want 000", {m_axi.awvalid, m_axi.wvalid, m_axi.bready}); else n_pass++;
      n_total++; if ({busy, frame_done, err} !== 3'b000)
         $display("FAIL reset_status: got %b want 000", {busy, frame_done, err}); else n_pass++;
      n_total++; if (m_axi.awaddr !== BASE)
         $display("FAIL reset_awaddr: got %h want %h", m_axi.awaddr, BASE); else n_pass++;
      n_total++; if ({m_axi.wdata, m_axi.wstrb, m_axi.awprot} !== 39'd0)
         $display("FAIL reset_wdata_wstrb: got %h/%h want 0/0", m_axi.wdata, m_axi.wstrb); else n_pass++;
      n_total++; if ({dut.r_phase, dut.r_tick} !== 14'd0)
         $display("FAIL reset_phase_tick: got %h/%h want 0/0", dut.r_phase, dut.r_tick); else n_pass++;
   endtask

   task automatic test_breathe_first_frame();
      logic ok; int n, bn, start;
      enable = 1'b1; mode = 2'd1;
      start = wr_cnt;
      do_reset();
      wait_awvalid(200, ok, n);
      n_total++; if (!ok || n != 65) $display("FAIL first_awvalid_cycle: got %0d want 65", n); else n_pass++;
      n_total++; if ({m_axi.wvalid, busy} !== 2'b11)
         $display("FAIL frame_start_wvalid_busy: got %b want 11", {m_axi.wvalid, busy}); else n_pass++;
      wait_frame_done(200, ok, n, bn);
      n_total++; if (!ok || n != 36) $display("FAIL frame_done_latency: got %0d want 36", n); else n_pass++;
      // busy was high in the awvalid cycle plus the 35 samples before frame_done
      n_total++; if (bn != 35 || busy !== 1'b0) $display("FAIL busy_width: got %0d+1 busy=%b want 35+1 busy=0", bn, busy); else n_pass++;
      n_total++; if (wr_cnt - start != 18) $display("FAIL breathe_write_count: got %0d want 18", wr_cnt - start); else n_pass++;
      for (int i = 0; i < 18; i++) begin
         n_total++;
         if (log_addr[(start + i) % 256] !== BASE + 32'(4 * i) || log_data[(start + i) % 256] !== exp_breathe0(i))
            $display("FAIL breathe_write_%0d: got %h=%h want %h=%h", i, log_addr[(start + i) % 256],
                     log_data[(start + i) % 256], BASE + 32'(4 * i), exp_breathe0(i));
         else n_pass++;
      end
      n_total++; if (dut.r_phase !== 8'd1) $display("FAIL phase_after_frame: got %0d want 1", dut.r_phase); else n_pass++;
   endtask

   task automatic test_chase_phase5();
      logic ok; int n, bn, start;
      logic [31:0] ed; logic [3:0] es;
      enable = 1'b1; mode = 2'd0;
      do_reset();
      for (int f = 0; f < 5; f++) begin
         wait_frame_done(200, ok, n, bn);
         n_total++; if (!ok) $display("FAIL chase_warmup_frame_%0d: got timeout want frame_done", f); else n_pass++;
      end
      start = wr_cnt;
      wait_awvalid(100, ok, n);
      mode = 2'd3;   // must not affect the frame already started
      wait_frame_done(200, ok, n, bn);
      n_total++; if (!ok || wr_cnt - start != 18) $display("FAIL chase_write_count: got %0d want 18", wr_cnt - start); else n_pass++;
      for (int i = 0; i < 18; i++) begin
         // phase 5: tri = 0x0A, so idx16 = F50A and idx17 = 0AF5
         ed = (i == 5) ? 32'h00 : (i < 16) ? 32'hFF : (i == 16) ? 32'hF50A : 32'h0AF5;
         es = (i < 16) ? 4'b0001 : 4'b0011;
         n_total++;
         if (log_addr[(start + i) % 256] !== BASE + 32'(4 * i) || log_data[(start + i) % 256] !== ed ||
             log_strb[(start + i) % 256] !== es)
            $display("FAIL chase_write_%0d: got %h=%h/%h want %h=%h/%h", i, log_addr[(start + i) % 256],
                     log_data[(start + i) % 256], log_strb[(start + i) % 256], BASE + 32'(4 * i), ed, es);
         else n_pass++;
      end
      n_total++; if (dut.r_phase !== 8'd6) $display("FAIL chase_phase: got %0d want 6", dut.r_phase); else n_pass++;
   endtask

   task automatic test_delayed_slave();
      logic ok; int n, bn, start, b0, s0;
      logic [31:0] ed;
      enable = 1'b1; mode = 2'd2; aw_delay = 3; w_delay = 1;
      do_reset();
      start = wr_cnt; b0 = b_cnt; s0 = stab_err;
      wait_awvalid(200, ok, n);
      repeat (2) @(negedge aclk);
      n_total++; if ({m_axi.awvalid, m_axi.wvalid} !== 2'b10)
         $display("FAIL delayed_valids_after_w: got %b want 10", {m_axi.awvalid, m_axi.wvalid}); else n_pass++;
      wait_frame_done(300, ok, n, bn);
      n_total++; if (!ok || wr_cnt - start != 18) $display("FAIL delayed_write_count: got %0d want 18", wr_cnt - start); else n_pass++;
      n_total++; if (b_cnt - b0 != 18) $display("FAIL delayed_b_count: got %0d want 18", b_cnt - b0); else n_pass++;
      n_total++; if (stab_err != s0) $display("FAIL delayed_stability: got %0d violations want 0", stab_err - s0); else n_pass++;
      for (int i = 0; i < 18; i++) begin
         ed = (i < 16) ? 32'h00FF : 32'hFFFF;
         n_total++;
         if (log_addr[(start + i) % 256] !== BASE + 32'(4 * i) || log_data[(start + i) % 256] !== ed)
            $display("FAIL delayed_write_%0d: got %h=%h want %h=%h", i, log_addr[(start + i) % 256],
                     log_data[(start + i) % 256], BASE + 32'(4 * i), ed);
         else n_pass++;
      end
      aw_delay = 0; w_delay = 0;
   endtask

   task automatic test_error_response();
      logic ok; int n, bn, start;
      enable = 1'b1; mode = 2'd3; err_idx = 7;
      do_reset();
      start = wr_cnt;
      wait_addr(BASE + 32'h1C, 200, ok);
      n_total++; if (!ok || err !== 1'b0) $display("FAIL err_before_idx7: got ok=%b err=%b want 1/0", ok, err); else n_pass++;
      wait_frame_done(200, ok, n, bn);
      n_total++; if (!ok || err !== 1'b1) $display("FAIL err_after_frame: got ok=%b err=%b want 1/1", ok, err); else n_pass++;
      n_total++; if (wr_cnt - start != 18 || log_addr[(start + 17) % 256] !== BASE + 32'h44)
         $display("FAIL err_frame_continues: got %0d writes, last %h want 18, %h", wr_cnt - start,
                  log_addr[(start + 17) % 256], BASE + 32'h44); else n_pass++;
      err_idx = -1;
      start = wr_cnt;
      wait_frame_done(200, ok, n, bn);
      n_total++; if (!ok || wr_cnt - start != 18 || err !== 1'b1)
         $display("FAIL err_next_frame: got ok=%b writes=%0d err=%b want 1/18/1", ok, wr_cnt - start, err); else n_pass++;
   endtask

   task automatic test_enable_drop();
      logic ok; int n, bn, start, seen;
      enable = 1'b1; mode = 2'd2;
      do_reset();
      start = wr_cnt;
      wait_addr(BASE + 32'h28, 200, ok);
      enable = 1'b0;
      wait_frame_done(200, ok, n, bn);
      n_total++; if (!ok || wr_cnt - start != 18 || log_addr[(start + 17) % 256] !== BASE + 32'h44)
         $display("FAIL enable_drop_finish: got %0d writes want 18", wr_cnt - start); else n_pass++;
      seen = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge aclk);
         if (m_axi.awvalid || busy) seen++;
      end
      n_total++; if (seen != 0) $display("FAIL enable_drop_idle: got %0d active cycles want 0", seen); else n_pass++;
      enable = 1'b1;
      wait_awvalid(70, ok, n);
      n_total++; if (!ok) $display("FAIL enable_return_start: got no frame within %0d cycles want start", n); else n_pass++;
      wait_frame_done(200, ok, n, bn);
   endtask

   task automatic test_reset_mid_frame();
      logic ok; int n, bn, start;
      enable = 1'b1; mode = 2'd1; aw_delay = 10;
      wait_awvalid(200, ok, n);
      n_total++; if (!ok || dut.r_state == 0) $display("FAIL midreset_setup: got ok=%b want awvalid in frame", ok); else n_pass++;
      aresetn = 1'b0;
      @(negedge aclk);
      n_total++; if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, busy} !== 4'b0000)
         $display("FAIL midreset_valids: got %b want 0000", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, busy}); else n_pass++;
      aw_delay = 0;
      aresetn = 1'b1;
      start = wr_cnt;
      wait_awvalid(200, ok, n);
      n_total++; if (!ok || n != 65) $display("FAIL midreset_tick_restart: got %0d want 65", n); else n_pass++;
      wait_frame_done(200, ok, n, bn);
      n_total++; if (!ok || wr_cnt - start != 18 || log_addr[start % 256] !== BASE)
         $display("FAIL midreset_first_idx: got %0d writes first %h want 18, %h", wr_cnt - start,
                  log_addr[start % 256], BASE); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_breathe_first_frame();
      test_chase_phase5();
      test_delayed_slave();
      test_error_response();
      test_enable_drop();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
